id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, operand/immediate width; REG_AW, default 3, register-address width.
REQ-002 clk  input  1  rising-edge clock, only clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 id_ctrl  input  11  decoded controls {ALU_OP, ALU_src, MEMW, MEMR, MTR, reg_write, Branch, In, Out, Stack_op, Push}, MSB first.
REQ-006 id_rdata1, id_rdata2, id_imm  input  DATA_W each  register-file operands and immediate.
REQ-007 id_rs, id_rt, id_rd  input  REG_AW each  source/destination register addresses.
REQ-008 id_uses_rt  input  1  instruction reads id_rt.
REQ-009 flush  input  1  branch-taken squash of the decode-stage instruction.
REQ-010 hold  input  1  downstream freeze; stage keeps its contents.
REQ-011 ex_valid  output  1  execute stage holds a real instruction.
REQ-012 ex_ctrl  output  11  registered controls, same bit order as id_ctrl.
REQ-013 ex_rdata1, ex_rdata2, ex_imm  output  DATA_W each  registered operands.
REQ-014 ex_rs, ex_rt, ex_rd  output  REG_AW each  registered addresses.
REQ-015 stall  output  1  combinational; freezes PC and IF/ID register when high.
REQ-016 bubble_cnt  output  8  saturating count of inserted bubbles.

Function
REQ-017 Load-use hazard (lu) SHALL be combinational: id_valid & ex_valid & ex_ctrl.MEMR & ex_ctrl.reg_write & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-018 stall SHALL equal lu | hold, and SHALL be 0 while flush is high.
REQ-019 At each rising edge the stage SHALL apply exactly one action, priority: flush > hold > lu > load.
REQ-020 flush: ex_valid<=0, ex_ctrl<=0; data/address registers don't-care (implementation holds them).
REQ-021 hold (no flush): every register including ex_valid SHALL keep its value.
REQ-022 lu (no flush, no hold): ex_valid<=0, ex_ctrl<=0 (bubble); decode inputs not captured; bubble_cnt increments.
REQ-023 load: all ex_* registers <= id_* inputs; ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0.
REQ-024 Latency SHALL be one cycle from id_* to ex_* on a load edge.
REQ-025 lu SHALL self-clear after one bubble because ex_valid becomes 0; a single load-use pair SHALL cost exactly one stall cycle.
REQ-026 bubble_cnt SHALL saturate at 255 and never wrap; flush-inserted bubbles SHALL NOT count.
REQ-027 No control bit SHALL reach ex_ctrl while ex_valid is 0 (ex_ctrl==0 whenever ex_valid==0).

Reset
REQ-028 rst_n low SHALL immediately clear all ex_* outputs, ex_valid and bubble_cnt to 0, independent of clk.
REQ-029 Reset deassertion SHALL take effect at the next rising edge; first edge after release performs normal priority action.
REQ-030 Reset asserted mid-hold or mid-stall SHALL discard the held instruction; stall SHALL read 0 while reset is low because ex_valid is 0.

Verification
REQ-031 Load: id_valid=1, id_ctrl=ADD controls (ALU_OP, reg_write), rdata1=0x0012 -> next edge ex_valid=1, ex_ctrl equal, ex_rdata1=0x0012, stall=0.
REQ-032 Load-use: ex holds LDD rd=3 (MEMR, reg_write); id ADD rs=3 -> stall=1; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1; following edge ADD loads, stall=0.
REQ-033 rt match with id_uses_rt=0 (ex LDD rd=2, id rt=2, rs=5) -> stall=0, no bubble.
REQ-034 Simultaneous flush and lu -> stall=0, ex_valid=0, bubble_cnt unchanged.
REQ-035 hold=1 for 3 cycles with STD loaded -> ex_* unchanged, stall=1; release -> next instruction loads.
REQ-036 Force 260 load-use pairs -> bubble_cnt=255; pulse rst_n low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, downstream hold and a saturating bubble counter.
package id_ex_stage_pkg;
    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 8;

    typedef struct packed {
        logic alu_op;
        logic alu_src;
        logic memw;
        logic memr;
        logic mtr;
        logic reg_write;
        logic branch;
        logic in_en;
        logic out_en;
        logic stack_op;
        logic push;
    } ctrl_t;
endpackage

module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_q,  ex_valid_d;
    ctrl_t             ex_ctrl_q,   ex_ctrl_d;
    logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d;
    logic [DATA_W-1:0] ex_rdata2_q, ex_rdata2_d;
    logic [DATA_W-1:0] ex_imm_q,    ex_imm_d;
    logic [REG_AW-1:0] ex_rs_q,     ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,     ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic lu;

    // A load in EX whose destination feeds the decode-stage instruction.
    always_comb begin
        lu = id_valid & ex_valid_q & ex_ctrl_q.memr & ex_ctrl_q.reg_write &
             ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
    end

    // Flush overrides any freeze; reset forces the freeze off as well.
    assign stall = rst_n & ~flush & (lu | hold);

    // One action per edge: flush > hold > load-use bubble > load.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_rdata1_d  = ex_rdata1_q;
        ex_rdata2_d  = ex_rdata2_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (hold) begin
            ex_valid_d = ex_valid_q;
        end else if (lu) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d  = id_valid;
            ex_ctrl_d   = id_valid ? ctrl_t'(id_ctrl) : '0;
            ex_rdata1_d = id_rdata1;
            ex_rdata2_d = id_rdata2;
            ex_imm_d    = id_imm;
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
            ex_rd_d     = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rdata1_q  <= '0;
            ex_rdata2_q  <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rdata1_q  <= ex_rdata1_d;
            ex_rdata2_q  <= ex_rdata2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rdata1  = ex_rdata1_q;
    assign ex_rdata2  = ex_rdata2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
